// File: rtl/redun_to_bin.sv
// rtl/redun_to_bin.sv - word-serial redundant-to-binary carry resolver for the Montgomery output path
// Optional single final subtraction of P is enabled by defining REDUN_TO_BIN_MOD_REDUCE_EN.
module redun_to_bin #(
  parameter int WRD_BITS = 4,
  parameter int NUM_WRDS = 4,
  parameter logic [NUM_WRDS*WRD_BITS-1:0] P = 16'hC35B
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [NUM_WRDS-1:0][WRD_BITS:0]     i_dat,
  input  logic                                i_val,
  output logic                                o_rdy,
  output logic [NUM_WRDS*WRD_BITS-1:0]        o_dat,
  output logic                                o_ovf,
  output logic                                o_val,
  input  logic                                i_rdy
);

  localparam int KW = $clog2(NUM_WRDS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CARRY, S_SUB, S_DONE} state_t;

  state_t                              r_state;
  logic [NUM_WRDS-1:0][WRD_BITS:0]     r_buf;
  logic [NUM_WRDS-1:0][WRD_BITS-1:0]   r_res;
  logic [1:0]                          r_carry;
  logic [KW-1:0]                       r_k;

  logic [WRD_BITS:0]                   w_cur;
  logic [WRD_BITS+1:0]                 w_sum;
  logic [NUM_WRDS-1:0][WRD_BITS-1:0]   w_res_nxt;
  logic                                w_last;

  assign w_last = (r_k == KW'(NUM_WRDS - 1));

  always_comb begin
    w_cur     = '0;
    w_res_nxt = r_res;
    for (int i = 0; i < NUM_WRDS; i++) begin
      if (r_k == KW'(i)) w_cur = r_buf[i];
    end
    w_sum = {1'b0, w_cur} + {{WRD_BITS{1'b0}}, r_carry};
    for (int i = 0; i < NUM_WRDS; i++) begin
      if (r_k == KW'(i)) w_res_nxt[i] = w_sum[WRD_BITS-1:0];
    end
  end

`ifdef REDUN_TO_BIN_MOD_REDUCE_EN
  logic [NUM_WRDS-1:0][WRD_BITS-1:0]   r_dbuf;
  logic                                r_borrow;
  logic [NUM_WRDS-1:0][WRD_BITS-1:0]   w_sub_nxt;
  logic [WRD_BITS-1:0]                 w_rk;
  logic [WRD_BITS-1:0]                 w_pk;
  logic [WRD_BITS:0]                   w_diff;

  always_comb begin
    w_rk      = '0;
    w_pk      = '0;
    w_sub_nxt = r_dbuf;
    for (int i = 0; i < NUM_WRDS; i++) begin
      if (r_k == KW'(i)) begin
        w_rk = r_res[i];
        w_pk = P[i*WRD_BITS +: WRD_BITS];
      end
    end
    w_diff = {1'b0, w_rk} - {1'b0, w_pk} - {{WRD_BITS{1'b0}}, r_borrow};
    for (int i = 0; i < NUM_WRDS; i++) begin
      if (r_k == KW'(i)) w_sub_nxt[i] = w_diff[WRD_BITS-1:0];
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      o_rdy   <= 1'b1;
      o_val   <= 1'b0;
      o_ovf   <= 1'b0;
      o_dat   <= '0;
      r_carry <= '0;
      r_k     <= '0;
`ifdef REDUN_TO_BIN_MOD_REDUCE_EN
      r_borrow <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_val && o_rdy) begin
            r_buf   <= i_dat;
            r_carry <= '0;
            r_k     <= '0;
            o_rdy   <= 1'b0;
            r_state <= S_CARRY;
          end
        end
        S_CARRY: begin
          r_res   <= w_res_nxt;
          r_carry <= w_sum[WRD_BITS+1:WRD_BITS];
          if (w_last) begin
            r_k <= '0;
`ifdef REDUN_TO_BIN_MOD_REDUCE_EN
            r_borrow <= 1'b0;
            r_state  <= S_SUB;
`else
            o_dat   <= w_res_nxt;
            o_ovf   <= (w_sum[WRD_BITS+1:WRD_BITS] != 2'b00);
            o_val   <= 1'b1;
            r_state <= S_DONE;
`endif
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
`ifdef REDUN_TO_BIN_MOD_REDUCE_EN
        S_SUB: begin
          r_dbuf   <= w_sub_nxt;
          r_borrow <= w_diff[WRD_BITS];
          if (w_last) begin
            r_k     <= '0;
            o_val   <= 1'b1;
            r_state <= S_DONE;
            // Top bits of ({carry,res} - P) are carry - borrow; a nonzero remainder means the result is still >= 2^W.
            if ((r_carry != 2'b00) || !w_diff[WRD_BITS]) begin
              o_dat <= w_sub_nxt;
              o_ovf <= ((r_carry - {1'b0, w_diff[WRD_BITS]}) != 2'b00);
            end else begin
              o_dat <= r_res;
              o_ovf <= 1'b0;
            end
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
`endif
        S_DONE: begin
          if (i_rdy) begin
            o_val   <= 1'b0;
            o_rdy   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_redun_to_bin.sv
// tb/tb_redun_to_bin.sv - self-checking bench for redun_to_bin against an integer-arithmetic model
// Honours REDUN_TO_BIN_MOD_REDUCE_EN to select the expected results and latency.
module tb_redun_to_bin;

  localparam int          WB    = 4;
  localparam int          NW    = 4;
  localparam int unsigned P_INT = 32'hC35B;
`ifdef REDUN_TO_BIN_MOD_REDUCE_EN
  localparam int          LAT   = 2 * NW + 1;
`else
  localparam int          LAT   = NW + 1;
`endif

  logic                      i_clk = 1'b0;
  logic                      i_rst;
  logic [NW-1:0][WB:0]       i_dat;
  logic                      i_val;
  logic                      o_rdy;
  logic [NW*WB-1:0]          o_dat;
  logic                      o_ovf;
  logic                      o_val;
  logic                      i_rdy;

  int n_checks = 0;
  int n_fail   = 0;

  redun_to_bin #(.WRD_BITS(WB), .NUM_WRDS(NW), .P(16'hC35B)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_dat(i_dat), .i_val(i_val), .o_rdy(o_rdy),
    .o_dat(o_dat), .o_ovf(o_ovf), .o_val(o_val), .i_rdy(i_rdy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: integer value of the redundant vector, optionally minus P once.
  function automatic void model(input logic [NW-1:0][WB:0] w, output logic [15:0] d, output logic ovf);
    int unsigned v;
    v = 0;
    for (int i = 0; i < NW; i++) v += int'(w[i]) << (WB * i);
`ifdef REDUN_TO_BIN_MOD_REDUCE_EN
    if (v >= P_INT) v -= P_INT;
`endif
    d   = 16'(v);
    ovf = (v >= 32'h10000);
  endfunction

  function automatic logic [NW-1:0][WB:0] rand_vec();
    logic [NW-1:0][WB:0] w;
    for (int i = 0; i < NW; i++) w[i] = 5'($urandom_range(0, 31));
    return w;
  endfunction

  task automatic run_one(input logic [NW-1:0][WB:0] w, input string tag);
    logic [15:0] ed;
    logic        eo;
    int          c;
    model(w, ed, eo);
    i_rdy = 1'b1;
    i_dat = w;
    i_val = 1'b1;
    c = 0;
    while (!o_rdy && c < 50) begin @(negedge i_clk); c++; end
    @(negedge i_clk);
    i_val = 1'b0;
    c = 1;
    while (!o_val && c < 50) begin @(negedge i_clk); c++; end
    check({tag, "_lat"}, c, LAT);
    check({tag, "_dat"}, o_dat, ed);
    check({tag, "_ovf"}, o_ovf, eo);
    @(negedge i_clk);
    check({tag, "_val_drop"}, o_val, 1'b0);
    check({tag, "_rdy_back"}, o_rdy, 1'b1);
  endtask

  logic [NW-1:0][WB:0] dir_tab [8];
  logic [15:0]         q_dat [$];
  logic                q_ovf [$];

  initial begin
    logic [15:0] ed, held;
    logic        eo, fired, seen;
    int          sent, got, c;

    i_rst = 1'b1; i_val = 1'b0; i_rdy = 1'b0; i_dat = '0;
    repeat (3) @(negedge i_clk);
    check("rst_rdy", o_rdy, 1'b1);
    check("rst_val", o_val, 1'b0);
    check("rst_ovf", o_ovf, 1'b0);
    check("rst_dat", o_dat, 16'h0);
    i_rst = 1'b0;
    @(negedge i_clk);

    dir_tab[0] = {5'h00, 5'h00, 5'h00, 5'h10};
    dir_tab[1] = {5'h1F, 5'h1F, 5'h1F, 5'h1F};
    dir_tab[2] = {5'h0D, 5'h00, 5'h00, 5'h00};
    dir_tab[3] = {5'h00, 5'h00, 5'h00, 5'h01};
    dir_tab[4] = {5'h0C, 5'h03, 5'h05, 5'h0B};
    dir_tab[5] = {5'h0C, 5'h03, 5'h05, 5'h0A};
    dir_tab[6] = {5'h0F, 5'h0F, 5'h0F, 5'h0F};
    dir_tab[7] = {5'h10, 5'h10, 5'h10, 5'h10};
    for (int i = 0; i < 8; i++) run_one(dir_tab[i], $sformatf("dir%0d", i));

    // Stalled output: result held, input side closed, extra request ignored.
    i_rdy = 1'b0;
    model(dir_tab[2], ed, eo);
    i_dat = dir_tab[2]; i_val = 1'b1;
    @(negedge i_clk);
    i_val = 1'b0;
    c = 1;
    while (!o_val && c < 50) begin @(negedge i_clk); c++; end
    check("stall_dat0", o_dat, ed);
    held = o_dat;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin i_dat = dir_tab[6]; i_val = 1'b1; end
      if (i == 6) i_val = 1'b0;
      @(negedge i_clk);
      check("stall_val", o_val, 1'b1);
      check("stall_dat", o_dat, held);
      check("stall_rdy", o_rdy, 1'b0);
    end
    i_val = 1'b0; i_rdy = 1'b1;
    @(negedge i_clk);
    check("stall_release", o_val, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 2 * LAT + 4; i++) begin
      @(negedge i_clk);
      if (o_val) seen = 1'b1;
    end
    check("stall_ignored", seen, 1'b0);
    run_one(dir_tab[3], "post_stall");

    // Reset in the middle of the carry pass.
    i_dat = dir_tab[1]; i_val = 1'b1;
    @(negedge i_clk);
    i_val = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("midrst_rdy", o_rdy, 1'b1);
    check("midrst_val", o_val, 1'b0);
    run_one(dir_tab[2], "post_rst");

    // Random stream with random handshakes on both sides.
    sent = 0; got = 0; fired = 1'b0;
    for (int cyc = 0; cyc < 4000 && got < 40; cyc++) begin
      @(negedge i_clk);
      if (fired) i_val = 1'b0;
      fired = 1'b0;
      if (!i_val && sent < 40 && $urandom_range(0, 2) != 0) begin
        i_dat = rand_vec();
        i_val = 1'b1;
      end
      i_rdy = 1'($urandom_range(0, 1));
      if (o_val && i_rdy) begin
        if (q_dat.size() == 0) begin
          check("rnd_unexpected", 32'd1, 32'd0);
        end else begin
          check("rnd_dat", o_dat, q_dat.pop_front());
          check("rnd_ovf", o_ovf, q_ovf.pop_front());
        end
        got++;
      end
      if (i_val && o_rdy) begin
        model(i_dat, ed, eo);
        q_dat.push_back(ed);
        q_ovf.push_back(eo);
        sent++;
        fired = 1'b1;
      end
    end
    check("rnd_count", got, 40);
    check("rnd_sent", sent, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
